// File: rtl/xor_stream_acc_pkg.sv
// Shared types for the XOR stream accumulator: operation codes and frame FSM states.
package xor_stream_pkg;

  typedef enum logic [1:0] {
    MODE_XOR  = 2'b00,
    MODE_XNOR = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_ALT  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

endpackage

// File: rtl/xor_stream_acc_if.sv
// Operand/result stream bundle for xor_stream_acc; the slave side is the block itself.
interface xor_stream_acc_if #(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic [1:0]    mode;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  f;
  logic          parity;
  logic [CW-1:0] count;

  modport master (
    output in_valid, x, y, mode, in_last, out_ready,
    input  in_ready, out_valid, f, parity, count
  );

  modport slave (
    input  in_valid, x, y, mode, in_last, out_ready,
    output in_ready, out_valid, f, parity, count
  );
endinterface

// File: rtl/xor_stream_acc_xor2.sv
// W-bit two-input XOR giving both the raw XOR and an optionally inverted copy.
module xor2_w #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         inv_i,
  output logic [W-1:0] xor_o,
  output logic [W-1:0] f_o
);

  assign xor_o = a_i ^ b_i;
  assign f_o   = inv_i ? ~xor_o : xor_o;

endmodule

// File: rtl/xor_stream_acc.sv
// One-deep registered XOR/XNOR stage with frame-fold mode; emits result, parity and beat count.
module xor_stream_acc
  import xor_stream_pkg::*;
#(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 5
) (
  input logic             clk,
  input logic             rst,
  xor_stream_acc_if.slave bus
);

  state_e        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] beats_q, beats_d;
  logic [W-1:0]  f_q, f_d;
  logic [CW-1:0] count_q, count_d;
  logic          parity_q, parity_d;
  logic          out_valid_q, out_valid_d;

  logic          in_ready;
  logic          accept;
  logic          produce;
  logic [W-1:0]  xy_xor, xy_res, fold, res;
  logic [CW-1:0] beats_inc, res_cnt;

  xor2_w #(.W(W)) u_xor2 (
    .a_i   (bus.x),
    .b_i   (bus.y),
    .inv_i (bus.mode == MODE_XNOR),
    .xor_o (xy_xor),
    .f_o   (xy_res)
  );

  assign in_ready  = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && in_ready;
  assign fold      = acc_q ^ xy_xor;
  // Beat counter sticks at all-ones; the XOR fold keeps running regardless.
  assign beats_inc = (beats_q == {CW{1'b1}}) ? beats_q : beats_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beats_d     = beats_q;
    f_d         = f_q;
    count_d     = count_q;
    parity_d    = parity_q;
    out_valid_d = out_valid_q;
    produce     = 1'b0;
    res         = '0;
    res_cnt     = '0;

    if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      unique case (state_q)
        ST_ACC: begin
          if (bus.in_last) begin
            produce = 1'b1;
            res     = fold;
            res_cnt = beats_inc;
            acc_d   = '0;
            beats_d = '0;
            state_d = ST_IDLE;
          end else begin
            acc_d   = fold;
            beats_d = beats_inc;
          end
        end
        default: begin
          if (bus.mode == MODE_ACC) begin
            if (bus.in_last) begin
              produce = 1'b1;
              res     = xy_xor;
              res_cnt = CW'(1);
            end else begin
              acc_d   = xy_xor;
              beats_d = CW'(1);
              state_d = ST_ACC;
            end
          end else begin
            // Mode 11 drives inv low, so it aliases plain XOR here.
            produce = 1'b1;
            res     = xy_res;
            res_cnt = CW'(1);
          end
        end
      endcase
    end

    if (produce) begin
      out_valid_d = 1'b1;
      f_d         = res;
      count_d     = res_cnt;
      parity_d    = ^res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      beats_q     <= '0;
      f_q         <= '0;
      count_q     <= '0;
      parity_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      f_q         <= f_d;
      count_q     <= count_d;
      parity_q    <= parity_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.f         = f_q;
  assign bus.parity    = parity_q;
  assign bus.count     = count_q;

endmodule
